booth_r4_mult: RTL and testbench

Sequential radix-4 Booth multiplier with an internal control FSM and valid/ready handshakes on both sides. It replaces the externally sequenced radix-2 datapath. It halves the iteration count, adds per-operation signed/unsigned selection, and holds results until the consumer accepts them. It sits between the operand-issue logic and the result sink in the arithmetic datapath, one operation in flight at a time.

---
 rtl/booth_r4_pkg.sv | 38 +++
 rtl/booth_r4_mult_if.sv | 24 ++
 rtl/booth_r4_encoder.sv | 22 ++
 rtl/booth_r4_mult.sv | 105 ++++++++++
 tb/tb_booth_r4_mult.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/booth_r4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Holds FSM states, Booth digit codes and operand extension.
package booth_r4_pkg;

   // Widest extended operand supported (N+2 must not exceed this).
   localparam int MAX_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } booth_digit_t;

   // Extends the low 'width' bits of v to MAX_W bits,
   // sign-extending when signed_mode is set.
   function automatic logic [MAX_W-1:0] ext_operand(
      input logic [MAX_W-1:0] v,
      input int               width,
      input logic             signed_mode
   );
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] msb;
      logic             fill;
      mask = (MAX_W'(1) << width) - MAX_W'(1);
      msb  = MAX_W'(1) << (width - 1);
      fill = signed_mode & (|(v & msb));
      return fill ? (v | ~mask) : (v & mask);
   endfunction

endpackage

// File: rtl/booth_r4_mult_if.sv
// Operand/result handshake bundle for booth_r4_mult.
// master: operand issuer and result sink; slave: the multiplier.
interface booth_r4_mult_if #(
   parameter int N = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           signed_mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] Y;

   modport master (
      output in_valid, A, B, signed_mode, out_ready,
      input  in_ready, out_valid, Y
   );

   modport slave (
      input  in_valid, A, B, signed_mode, out_ready,
      output in_ready, out_valid, Y
   );
endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: {b[i+1], b[i], b[i-1]} -> digit.
// Ports: win (3-bit window in), digit (booth_digit_t out).
module booth_r4_encoder
   import booth_r4_pkg::*;
(
   input  logic [2:0]   win,
   output booth_digit_t digit
);

   always_comb begin
      digit = ZERO;
      unique case (win)
         3'b000, 3'b111: digit = ZERO;
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase
   end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per op.
// Ports: clk, rst (async high), bus (booth_r4_mult_if.slave).
module booth_r4_mult
   import booth_r4_pkg::*;
#(
   parameter int N = 8
) (
   input  logic            clk,
   input  logic            rst,
   booth_r4_mult_if.slave  bus
);

   localparam int K  = N / 2 + 1;
   localparam int CW = $clog2(K);

   state_t       state;
   logic [CW-1:0] cnt;
   logic [N+1:0] m_q;
   logic [N+1:0] l_q;
   logic [N+3:0] h_q;
   logic         q1_q;

   booth_digit_t digit;
   logic [N+3:0] m_ext;
   logic [N+3:0] term;
   logic [N+3:0] h_sum;
   logic [N+3:0] h_sh;
   logic [N+1:0] l_sh;
   logic [2*N-1:0] prod_next;

   booth_r4_encoder u_enc (
      .win   ({l_q[1:0], q1_q}),
      .digit (digit)
   );

   assign m_ext = {{2{m_q[N+1]}}, m_q};

   always_comb begin
      term = '0;
      unique case (digit)
         ZERO:    term = '0;
         POS1:    term = m_ext;
         POS2:    term = m_ext << 1;
         NEG1:    term = -m_ext;
         NEG2:    term = -(m_ext << 1);
         default: term = '0;
      endcase
   end

   // Arithmetic shift of {H', L, Q_1} right by two.
   assign h_sum     = h_q + term;
   assign h_sh      = {{2{h_sum[N+3]}}, h_sum[N+3:2]};
   assign l_sh      = {h_sum[1:0], l_q[N+1:2]};
   assign prod_next = {h_sh[N-3:0], l_sh};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.Y         <= '0;
         cnt           <= '0;
         m_q           <= '0;
         l_q           <= '0;
         h_q           <= '0;
         q1_q          <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  m_q <= (N+2)'(ext_operand(
                     MAX_W'(bus.A), N, bus.signed_mode));
                  l_q <= (N+2)'(ext_operand(
                     MAX_W'(bus.B), N, bus.signed_mode));
                  h_q          <= '0;
                  q1_q         <= 1'b0;
                  cnt          <= CW'(K - 1);
                  bus.in_ready <= 1'b0;
                  state        <= CALC;
               end
            end
            CALC: begin
               h_q  <= h_sh;
               l_q  <= l_sh;
               q1_q <= l_q[1];
               cnt  <= cnt - CW'(1);
               if (cnt == '0) begin
                  bus.Y         <= prod_next;
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Directed and random checks of booth_r4_mult at N=8 and N=16.
// Drives both instances through their handshake interfaces.
module tb_booth_r4_mult;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   booth_r4_mult_if #(.N(8))  i8 ();
   booth_r4_mult_if #(.N(16)) i16 ();

   booth_r4_mult #(.N(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (i8.slave)
   );

   booth_r4_mult #(.N(16)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (i16.slave)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start8(input logic [7:0] a,
                         input logic [7:0] b,
                         input logic sm);
      i8.A = a;
      i8.B = b;
      i8.signed_mode = sm;
      i8.in_valid = 1'b1;
      tick();
      i8.in_valid = 1'b0;
   endtask

   task automatic wait8(output int n);
      n = 0;
      while (i8.out_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic op8(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic sm,
                      input logic [15:0] exp,
                      input string tag);
      int n;
      chk({tag, "_rdy"}, 32'(i8.in_ready), 32'd1);
      start8(a, b, sm);
      chk({tag, "_busy"}, 32'(i8.in_ready), 32'd0);
      wait8(n);
      chk({tag, "_lat"}, 32'(n), 32'd5);
      chk({tag, "_y"}, 32'(i8.Y), 32'(exp));
      i8.out_ready = 1'b1;
      tick();
      i8.out_ready = 1'b0;
      chk({tag, "_ov0"}, 32'(i8.out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(i8.in_ready), 32'd1);
   endtask

   task automatic op16(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic sm,
                       input logic [31:0] exp,
                       input string tag);
      int n;
      i16.A = a;
      i16.B = b;
      i16.signed_mode = sm;
      i16.in_valid = 1'b1;
      tick();
      i16.in_valid = 1'b0;
      n = 0;
      while (i16.out_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd9);
      chk({tag, "_y"}, i16.Y, exp);
      i16.out_ready = 1'b1;
      tick();
      i16.out_ready = 1'b0;
      chk({tag, "_idle"}, 32'(i16.in_ready), 32'd1);
   endtask

   initial begin
      int         n;
      longint     p;
      logic [7:0]  a8, b8;
      logic [15:0] a16, b16;
      logic        sm;

      rst = 1'b1;
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b0;
      i8.A = '0;
      i8.B = '0;
      i8.signed_mode = 1'b0;
      i16.in_valid = 1'b0;
      i16.out_ready = 1'b0;
      i16.A = '0;
      i16.B = '0;
      i16.signed_mode = 1'b0;

      tick();
      tick();
      chk("rst_ir", 32'(i8.in_ready), 32'd1);
      chk("rst_ov", 32'(i8.out_valid), 32'd0);
      chk("rst_y", 32'(i8.Y), 32'd0);
      chk("rst_y16", i16.Y, 32'd0);
      rst = 1'b0;
      tick();

      op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128sq");
      op8(8'd127, 8'hFF, 1'b1, 16'hFF81, "s_127xm1");
      op8(8'd0, 8'hB3, 1'b1, 16'h0000, "s_0xm77");
      op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255sq");
      op8(8'h80, 8'h02, 1'b0, 16'h0100, "u_128x2");

      // Back-pressure: 12 * -3 = -36 held for 10 cycles.
      start8(8'd12, 8'hFD, 1'b1);
      wait8(n);
      chk("bp_lat", 32'(n), 32'd5);
      for (int i = 0; i < 10; i++) begin
         chk("bp_y", 32'(i8.Y), 32'h0000FFDC);
         chk("bp_ir", 32'(i8.in_ready), 32'd0);
         chk("bp_ov", 32'(i8.out_valid), 32'd1);
         i8.in_valid = i[0];
         i8.A = 8'(i + 3);
         i8.B = 8'(i + 7);
         tick();
      end
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b1;
      tick();
      i8.out_ready = 1'b0;
      chk("bp_idle_ir", 32'(i8.in_ready), 32'd1);
      chk("bp_idle_ov", 32'(i8.out_valid), 32'd0);
      chk("bp_hold_y", 32'(i8.Y), 32'h0000FFDC);
      tick();
      chk("bp_noacc", 32'(i8.in_ready), 32'd1);

      // Same-cycle out_ready and in_valid in DONE.
      start8(8'd5, 8'd6, 1'b0);
      wait8(n);
      chk("sc_y", 32'(i8.Y), 32'd30);
      i8.A = 8'd9;
      i8.B = 8'd9;
      i8.in_valid = 1'b1;
      i8.out_ready = 1'b1;
      tick();
      i8.in_valid = 1'b0;
      i8.out_ready = 1'b0;
      chk("sc_ov", 32'(i8.out_valid), 32'd0);
      chk("sc_ir", 32'(i8.in_ready), 32'd1);
      tick();
      chk("sc_noacc", 32'(i8.in_ready), 32'd1);
      chk("sc_keep_y", 32'(i8.Y), 32'd30);

      // Reset during the second CALC cycle.
      start8(8'd100, 8'd100, 1'b0);
      tick();
      rst = 1'b1;
      #1;
      chk("mr_ov", 32'(i8.out_valid), 32'd0);
      chk("mr_ir", 32'(i8.in_ready), 32'd1);
      chk("mr_y", 32'(i8.Y), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("mr_still", 32'(i8.out_valid), 32'd0);
      op8(8'd3, 8'd5, 1'b1, 16'd15, "mr_3x5");

      op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "d16_s");
      op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "d16_u");

      for (int i = 0; i < 500; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         sm = 1'($urandom_range(0, 1));
         if (sm)
            p = longint'($signed(a8)) * longint'($signed(b8));
         else
            p = longint'(a8) * longint'(b8);
         op8(a8, b8, sm, 16'(p), "r8");
      end

      for (int i = 0; i < 500; i++) begin
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         sm = 1'($urandom_range(0, 1));
         if (sm)
            p = longint'($signed(a16)) * longint'($signed(b16));
         else
            p = longint'(a16) * longint'(b16);
         op16(a16, b16, sm, 32'(p), "r16");
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
